// File: rtl/poly6_sdiv_32s_16s_32_seq_if.sv
// Handshake and operand/result bundle for the poly6 sequential signed divider.
// Signals: ap_start/ap_ready/ap_idle/ap_done control, din0/din1 in, dout_quot/dout_rem/div_by_zero out.
interface poly6_sdiv_32s_16s_32_seq_if #(
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 16
);
    logic                      ap_start;
    logic                      ap_ready;
    logic                      ap_idle;
    logic                      ap_done;
    logic [DIVIDEND_WIDTH-1:0] din0;
    logic [DIVISOR_WIDTH-1:0]  din1;
    logic [DIVIDEND_WIDTH-1:0] dout_quot;
    logic [DIVISOR_WIDTH-1:0]  dout_rem;
    logic                      div_by_zero;

    modport master (
        output ap_start,
        output din0,
        output din1,
        input  ap_ready,
        input  ap_idle,
        input  ap_done,
        input  dout_quot,
        input  dout_rem,
        input  div_by_zero
    );

    modport slave (
        input  ap_start,
        input  din0,
        input  din1,
        output ap_ready,
        output ap_idle,
        output ap_done,
        output dout_quot,
        output dout_rem,
        output div_by_zero
    );
endinterface

// File: rtl/poly6_sdiv_32s_16s_32_seq.sv
// Multi-cycle signed divider (C truncating): one restoring step per cycle.
// Ports: ap_clk, ap_rst (sync, active-high), bus (slave: start/ready/idle/done, din0/din1, quot/rem/div_by_zero).
module poly6_sdiv_32s_16s_32_seq #(
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 16
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    poly6_sdiv_32s_16s_32_seq_if.slave    bus
);
    localparam int DW = DIVIDEND_WIDTH;
    localparam int VW = DIVISOR_WIDTH;
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CW-1:0] cnt;
    // Dividend magnitude; quotient bits shift in from the bottom as
    // dividend bits leave the top, so after DW steps it holds |quot|.
    logic [DW-1:0] dvd;
    logic [VW-1:0] dsr;
    logic [VW:0]   prem;
    logic [VW-1:0] din0_lo;
    logic          sign_a;
    logic          sign_b;
    logic          zero_b;

    logic [DW-1:0] a_mag;
    logic [VW-1:0] b_mag;
    logic [VW+1:0] trial;
    logic          ge;
    logic [DW-1:0] q_fix;
    logic [VW-1:0] r_fix;

    always_comb begin
        a_mag = bus.din0[DW-1] ? (DW'(0) - bus.din0) : bus.din0;
        b_mag = bus.din1[VW-1] ? (VW'(0) - bus.din1) : bus.din1;
    end

    // Both operands stay below 2^(VW+1), so bit VW+1 of the
    // difference is the borrow of the trial subtraction.
    always_comb begin
        trial = {prem, dvd[DW-1]} - {2'b00, dsr};
        ge    = ~trial[VW+1];
    end

    always_comb begin
        q_fix = (sign_a ^ sign_b) ? (DW'(0) - dvd) : dvd;
        r_fix = sign_a ? (VW'(0) - prem[VW-1:0]) : prem[VW-1:0];
        if (zero_b) begin
            q_fix = '1;
            r_fix = din0_lo;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        bus.ap_idle  = 1'b0;
        bus.ap_ready = 1'b0;
        unique case (state)
            S_IDLE: begin
                bus.ap_idle  = 1'b1;
                bus.ap_ready = bus.ap_start;
                if (bus.ap_start) begin
                    state_nx = S_CALC;
                end
            end
            S_CALC: begin
                if (cnt == CW'(1)) begin
                    state_nx = S_FIX;
                end
            end
            S_FIX: begin
                state_nx = S_DONE;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            cnt             <= '0;
            dvd             <= '0;
            dsr             <= '0;
            prem            <= '0;
            din0_lo         <= '0;
            sign_a          <= 1'b0;
            sign_b          <= 1'b0;
            zero_b          <= 1'b0;
            bus.ap_done     <= 1'b0;
            bus.dout_quot   <= '0;
            bus.dout_rem    <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.ap_done <= (state == S_FIX);
            unique case (state)
                S_IDLE: begin
                    if (bus.ap_start) begin
                        cnt     <= CW'(DW);
                        dvd     <= a_mag;
                        dsr     <= b_mag;
                        prem    <= '0;
                        din0_lo <= bus.din0[VW-1:0];
                        sign_a  <= bus.din0[DW-1];
                        sign_b  <= bus.din1[VW-1];
                        zero_b  <= (bus.din1 == '0);
                    end
                end
                S_CALC: begin
                    cnt  <= cnt - CW'(1);
                    dvd  <= {dvd[DW-2:0], ge};
                    prem <= ge ? trial[VW:0]
                               : {prem[VW-1:0], dvd[DW-1]};
                end
                S_FIX: begin
                    bus.dout_quot   <= q_fix;
                    bus.dout_rem    <= r_fix;
                    bus.div_by_zero <= zero_b;
                end
                S_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_poly6_sdiv_32s_16s_32_seq.sv
// Directed bench for the poly6 sequential signed divider.
// Checks reset, latency, signs, extremes, divide-by-zero, start ignoring, mid-run reset.
module tb_poly6_sdiv_32s_16s_32_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    poly6_sdiv_32s_16s_32_seq_if #(
        .DIVIDEND_WIDTH(32),
        .DIVISOR_WIDTH(16)
    ) bus ();

    poly6_sdiv_32s_16s_32_seq dut (
        .ap_clk(clk),
        .ap_rst(rst),
        .bus(bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag,
                       input logic [31:0] a, input logic [15:0] b,
                       input logic [31:0] eq, input logic [15:0] er,
                       input logic ez, input bit hold, input bit perturb);
        @(negedge clk);
        bus.ap_start = 1'b1;
        bus.din0 = a;
        bus.din1 = b;
        #1;
        chk({tag, " ready"}, 32'(bus.ap_ready), 32'd1);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k == 1 && !hold) bus.ap_start = 1'b0;
            if (perturb && k == 5) begin
                bus.ap_start = 1'b1;
                bus.din0 = 32'h0000_0001;
                bus.din1 = 16'h0001;
            end
            if (perturb && k == 6) bus.ap_start = 1'b0;
            #1;
            chk({tag, " done"}, 32'(bus.ap_done), 32'(k == 34));
            chk({tag, " busy_ready"}, 32'(bus.ap_ready), 32'd0);
            chk({tag, " idle"}, 32'(bus.ap_idle), 32'd0);
        end
        chk({tag, " quot"}, bus.dout_quot, eq);
        chk({tag, " rem"}, 32'(bus.dout_rem), 32'(er));
        chk({tag, " dbz"}, 32'(bus.div_by_zero), 32'(ez));
    endtask

    initial begin
        bit saw_done;
        bus.ap_start = 1'b0;
        bus.din0 = '0;
        bus.din1 = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst idle", 32'(bus.ap_idle), 32'd1);
        chk("rst ready", 32'(bus.ap_ready), 32'd0);
        chk("rst done", 32'(bus.ap_done), 32'd0);
        chk("rst quot", bus.dout_quot, 32'd0);
        chk("rst rem", 32'(bus.dout_rem), 32'd0);
        chk("rst dbz", 32'(bus.div_by_zero), 32'd0);
        rst = 1'b0;

        run("p100_7", 32'd100, 16'd7, 32'd14, 16'd2, 1'b0, 0, 0);
        run("n100_7", -32'sd100, 16'd7,
            32'hFFFF_FFF2, 16'hFFFE, 1'b0, 0, 0);
        run("p100_n7", 32'd100, -16'sd7,
            32'hFFFF_FFF2, 16'h0002, 1'b0, 0, 0);
        run("n100_n7", -32'sd100, -16'sd7,
            32'h0000_000E, 16'hFFFE, 1'b0, 0, 0);
        run("min_m1", 32'h8000_0000, 16'hFFFF,
            32'h8000_0000, 16'h0000, 1'b0, 0, 0);
        run("min_min", 32'h8000_0000, 16'h8000,
            32'h0001_0000, 16'h0000, 1'b0, 0, 0);
        run("max_max", 32'h7FFF_FFFF, 16'h7FFF,
            32'h0001_0002, 16'h0001, 1'b0, 0, 0);
        run("dz", 32'h1234_5678, 16'h0000,
            32'hFFFF_FFFF, 16'h5678, 1'b1, 0, 0);
        run("after_dz", 32'd10, 16'd3, 32'd3, 16'd1, 1'b0, 0, 0);

        run("hold1", 32'd1000, 16'd10, 32'd100, 16'd0, 1'b0, 1, 0);
        run("hold2", -32'sd77, 16'd5,
            32'hFFFF_FFF1, 16'hFFFE, 1'b0, 1, 0);
        run("hold3", 32'd50, 16'd6, 32'd8, 16'd2, 1'b0, 0, 0);

        run("perturb", 32'd12345, -16'sd100,
            32'hFFFF_FF85, 16'h002D, 1'b0, 0, 1);

        @(negedge clk);
        bus.ap_start = 1'b1;
        bus.din0 = 32'd1000;
        bus.din1 = 16'd3;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) bus.ap_start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst idle", 32'(bus.ap_idle), 32'd1);
        chk("mid_rst done", 32'(bus.ap_done), 32'd0);
        chk("mid_rst quot", bus.dout_quot, 32'd0);
        chk("mid_rst rem", 32'(bus.dout_rem), 32'd0);
        chk("mid_rst dbz", 32'(bus.div_by_zero), 32'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (bus.ap_done === 1'b1) saw_done = 1'b1;
        end
        chk("mid_rst no_done", 32'(saw_done), 32'd0);

        run("post_rst", 32'd9, 16'd4, 32'd2, 16'd1, 1'b0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
